cdb_multi_bcast: RTL and testbench
==================================

// Module: cdb_multi_bcast
// PURPOSE
//  Parametrised multi-port common data bus. Sits between the X/C pipeline register and the PR file, RS, ROB and map table.
//  Each FU owns a small completion buffer; up to CDB_W completions are broadcast per cycle, granted round-robin across FUs.
//  Rollback squashes buffered results younger than the mispredicted branch or faulting load, including ROB index wrap-around.
// PARAMETERS
//  NUM_FU     6   number of FU result channels
//  CDB_W      2   broadcast ports per cycle (1..NUM_FU)
//  BUF_DEPTH  2   completion-buffer entries per FU (>=1)
//  ROB_W      5   ROB index width ($clog2(NUM_ROB))
//  PR_W       6   physical register tag width
//  DATA_W     64  result width
// PORTS
//  clock             in   1               system clock
//  reset             in   1               synchronous, active-low (0 = reset)
//  en                in   1               advance enable
//  rollback_en       in   1               squash request
//  rollback_rob_idx  in   ROB_W           ROB index of the rollback instruction
//  diff_rob          in   ROB_W           ROB tail - rollback_rob_idx (mod 2^ROB_W)
//  fu_done           in   NUM_FU          per-FU result valid
//  fu_t_idx          in   NUM_FU*PR_W     destination PR tag
//  fu_rob_idx        in   NUM_FU*ROB_W    ROB index
//  fu_dest_idx       in   NUM_FU*5        architectural dest register
//  fu_result         in   NUM_FU*DATA_W   result value
//  fu_ready          out  NUM_FU          buffer can accept a result this cycle
//  cdb_valid         out  CDB_W           broadcast port valid (complete_en / PR write_en)
//  cdb_t_idx         out  CDB_W*PR_W      broadcast tag
//  cdb_rob_idx       out  CDB_W*ROB_W     broadcast ROB index
//  cdb_dest_idx      out  CDB_W*5         broadcast arch register
//  cdb_value         out  CDB_W*DATA_W    broadcast value
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all buffers empty, rr_ptr=0. After reset: cdb_valid=0, fu_ready all 1 (when en=1).
//  - Buffer: per-FU ordered shift queue holding BUF_DEPTH entries, each with a valid bit and count_i.
//    fu_ready[i] = en & (count_i < BUF_DEPTH). The current count is used; a same-cycle pop does not free space.
//  - Push: fu_done[i] & fu_ready[i] at a posedge appends the entry at the tail. fu_done while not ready is a protocol error.
//    The FU must hold its result.
//  - Latency: a result pushed at edge t is broadcast no earlier than the cycle after t. There is no same-cycle bypass.
//  - Arbitration: candidates are the heads of non-empty buffers. Scan from rr_ptr upward, mod NUM_FU.
//    The first CDB_W candidates go to ports 0..CDB_W-1 in scan order.
//    Unused ports: cdb_valid=0, data fields 0.
//  - Broadcast outputs are combinational from registered heads. Granted heads pop at the next posedge if en=1.
//  - rr_ptr <= (index of the last granted FU + 1) mod NUM_FU. It is unchanged if nothing is granted.
//  - Squash test: d = (entry.rob_idx - rollback_rob_idx) mod 2^ROB_W. The entry is squashed iff rollback_en & 0 < d <= diff_rob.
//    The rollback instruction itself (d=0) survives.
//  - Rollback applies in the same cycle to:
//    - broadcasts: a squashed head has its cdb_valid masked, and the grant passes to the next candidate;
//    - buffered entries: invalidated at the edge, survivors compact toward the head in order;
//    - incoming pushes: a squashed push is dropped.
//  - Rollback is honoured even when en=0: squashed entries are removed and nothing else changes.
//  - en=0 (and no rollback): state frozen, cdb_valid=0, fu_ready=0.
//  - Simultaneous push and pop on one FU: count unchanged, the new entry goes behind the survivors.
//  - Reset mid-operation drops all buffered results and emits no broadcast in the reset cycle.
// TESTING
//  1. Hold reset=0 for 2 cycles with fu_done=all 1.
//     -> cdb_valid=0, no entries stored; after reset=1, fu_ready=6'b111111.
//  2. FU2 done, t_idx=9, value=0xDEAD, at edge t.
//     -> at cycle t+1: port0 valid, t_idx=9, value=0xDEAD; port1 invalid; at t+2 nothing is broadcast.
//  3. FU0, FU1 and FU4 done together, rr_ptr=0, CDB_W=2.
//     -> cycle 1: ports carry FU0 and FU1, rr_ptr becomes 2.
//     -> cycle 2: port0 carries FU4, rr_ptr becomes 5.
//  4. Drive FU3 done for 3 consecutive cycles with no grants (en gating ports busy via higher-priority FUs), BUF_DEPTH=2.
//     -> fu_ready[3]=0 after 2 pushes; the third result is held by the FU and accepted only once an entry pops.
//  5. Buffered rob_idx 31, 1 and 3; rollback_rob_idx=30, diff_rob=4.
//     -> 31 (d=1) and 1 (d=3) are squashed, 3 (d=5) survives, and the next broadcast is rob_idx 3 only.
//  6. en=0 for 3 cycles with full buffers, plus one rollback pulse.
//     -> no broadcasts, fu_ready=0; only younger entries disappear; broadcasting resumes in order when en=1.

Source files
------------

// File: rtl/cdb_multi_bcast.sv
// rtl/cdb_multi_bcast.sv - multi-port common data bus with per-FU completion buffers and rollback squash
module cdb_multi_bcast #(
  parameter int NUM_FU    = 6,
  parameter int CDB_W     = 2,
  parameter int BUF_DEPTH = 2,
  parameter int ROB_W     = 5,
  parameter int PR_W      = 6,
  parameter int DATA_W    = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     rollback_en,
  input  logic [ROB_W-1:0]         rollback_rob_idx,
  input  logic [ROB_W-1:0]         diff_rob,
  input  logic [NUM_FU-1:0]        fu_done,
  input  logic [NUM_FU*PR_W-1:0]   fu_t_idx,
  input  logic [NUM_FU*ROB_W-1:0]  fu_rob_idx,
  input  logic [NUM_FU*5-1:0]      fu_dest_idx,
  input  logic [NUM_FU*DATA_W-1:0] fu_result,
  output logic [NUM_FU-1:0]        fu_ready,
  output logic [CDB_W-1:0]         cdb_valid,
  output logic [CDB_W*PR_W-1:0]    cdb_t_idx,
  output logic [CDB_W*ROB_W-1:0]   cdb_rob_idx,
  output logic [CDB_W*5-1:0]       cdb_dest_idx,
  output logic [CDB_W*DATA_W-1:0]  cdb_value
);
  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [PR_W-1:0]   t_idx;
    logic [ROB_W-1:0]  rob_idx;
    logic [4:0]        dest_idx;
    logic [DATA_W-1:0] value;
  } ent_t;

  // Queues are kept compacted: valid entries always occupy slots 0..count-1.
  ent_t                 q_ent  [NUM_FU][BUF_DEPTH];
  logic [BUF_DEPTH-1:0] q_vld  [NUM_FU];
  ent_t                 nx_ent [NUM_FU][BUF_DEPTH];
  logic [BUF_DEPTH-1:0] nx_vld [NUM_FU];
  logic [RR_W-1:0]      rr_ptr;
  logic [RR_W-1:0]      nx_rr;
  logic [NUM_FU-1:0]    cand;
  logic [NUM_FU-1:0]    grant;
  int                   rank [NUM_FU];

  // Younger than the rollback instruction (modular distance 1..diff_rob) means squashed.
  function automatic logic squashed(input logic [ROB_W-1:0] rob, input logic rb_en,
                                    input logic [ROB_W-1:0] rb_idx, input logic [ROB_W-1:0] rb_diff);
    logic [ROB_W-1:0] d;
    d = rob - rb_idx;
    return rb_en && (d != '0) && (d <= rb_diff);
  endfunction

  // A buffer accepts only while it has a free slot by its current occupancy.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = en && !q_vld[i][BUF_DEPTH-1];
    end
  end

  // Round-robin grant: rank each live head by its scan position from rr_ptr.
  always_comb begin
    int pos_i;
    int pos_j;
    int last_pos;
    cand     = '0;
    grant    = '0;
    nx_rr    = rr_ptr;
    last_pos = -1;
    for (int i = 0; i < NUM_FU; i++) begin
      cand[i] = reset && en && q_vld[i][0] &&
                !squashed(q_ent[i][0].rob_idx, rollback_en, rollback_rob_idx, diff_rob);
    end
    for (int i = 0; i < NUM_FU; i++) begin
      rank[i] = 0;
      pos_i = i - int'(rr_ptr);
      if (pos_i < 0) pos_i = pos_i + NUM_FU;
      for (int j = 0; j < NUM_FU; j++) begin
        pos_j = j - int'(rr_ptr);
        if (pos_j < 0) pos_j = pos_j + NUM_FU;
        if (cand[j] && (pos_j < pos_i)) rank[i] = rank[i] + 1;
      end
      if (cand[i] && (rank[i] < CDB_W)) begin
        grant[i] = 1'b1;
        if (pos_i > last_pos) begin
          last_pos = pos_i;
          nx_rr    = (i == NUM_FU - 1) ? '0 : RR_W'(i + 1);
        end
      end
    end
  end

  // Drive each broadcast port from the granted head whose rank matches the port.
  always_comb begin
    cdb_valid    = '0;
    cdb_t_idx    = '0;
    cdb_rob_idx  = '0;
    cdb_dest_idx = '0;
    cdb_value    = '0;
    for (int p = 0; p < CDB_W; p++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i] && (rank[i] == p)) begin
          cdb_valid[p]                   = 1'b1;
          cdb_t_idx[p*PR_W +: PR_W]      = q_ent[i][0].t_idx;
          cdb_rob_idx[p*ROB_W +: ROB_W]  = q_ent[i][0].rob_idx;
          cdb_dest_idx[p*5 +: 5]         = q_ent[i][0].dest_idx;
          cdb_value[p*DATA_W +: DATA_W]  = q_ent[i][0].value;
        end
      end
    end
  end

  // Next queue contents: drop popped and squashed entries, compact survivors, append push at tail.
  always_comb begin
    int   kept;
    logic push_ok;
    for (int i = 0; i < NUM_FU; i++) begin
      nx_vld[i] = '0;
      for (int b = 0; b < BUF_DEPTH; b++) nx_ent[i][b] = '0;
      kept = 0;
      for (int b = 0; b < BUF_DEPTH; b++) begin
        if (q_vld[i][b] && !(b == 0 && grant[i]) &&
            !squashed(q_ent[i][b].rob_idx, rollback_en, rollback_rob_idx, diff_rob)) begin
          for (int w = 0; w < BUF_DEPTH; w++) begin
            if (w == kept) begin
              nx_vld[i][w] = 1'b1;
              nx_ent[i][w] = q_ent[i][b];
            end
          end
          kept = kept + 1;
        end
      end
      push_ok = fu_done[i] && fu_ready[i] &&
                !squashed(fu_rob_idx[i*ROB_W +: ROB_W], rollback_en, rollback_rob_idx, diff_rob);
      if (push_ok) begin
        for (int w = 0; w < BUF_DEPTH; w++) begin
          if (w == kept) begin
            nx_vld[i][w]          = 1'b1;
            nx_ent[i][w].t_idx    = fu_t_idx[i*PR_W +: PR_W];
            nx_ent[i][w].rob_idx  = fu_rob_idx[i*ROB_W +: ROB_W];
            nx_ent[i][w].dest_idx = fu_dest_idx[i*5 +: 5];
            nx_ent[i][w].value    = fu_result[i*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // State register: reset empties every buffer and rewinds the round-robin pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        q_vld[i] <= '0;
        for (int b = 0; b < BUF_DEPTH; b++) q_ent[i][b] <= '0;
      end
    end else begin
      rr_ptr <= nx_rr;
      q_vld  <= nx_vld;
      q_ent  <= nx_ent;
    end
  end
endmodule

// File: tb/tb_cdb_multi_bcast.sv
// tb/tb_cdb_multi_bcast.sv - scoreboard bench for cdb_multi_bcast
module tb_cdb_multi_bcast;
  localparam int NUM_FU = 6, CDB_W = 2, BUF_DEPTH = 2, ROB_W = 5, PR_W = 6, DATA_W = 64;

  logic                     clock = 1'b0;
  logic                     reset = 1'b0;
  logic                     en = 1'b0;
  logic                     rollback_en = 1'b0;
  logic [ROB_W-1:0]         rollback_rob_idx = '0;
  logic [ROB_W-1:0]         diff_rob = '0;
  logic [NUM_FU-1:0]        fu_done = '0;
  logic [NUM_FU*PR_W-1:0]   fu_t_idx = '0;
  logic [NUM_FU*ROB_W-1:0]  fu_rob_idx = '0;
  logic [NUM_FU*5-1:0]      fu_dest_idx = '0;
  logic [NUM_FU*DATA_W-1:0] fu_result = '0;
  logic [NUM_FU-1:0]        fu_ready;
  logic [CDB_W-1:0]         cdb_valid;
  logic [CDB_W*PR_W-1:0]    cdb_t_idx;
  logic [CDB_W*ROB_W-1:0]   cdb_rob_idx;
  logic [CDB_W*5-1:0]       cdb_dest_idx;
  logic [CDB_W*DATA_W-1:0]  cdb_value;

  cdb_multi_bcast #(.NUM_FU(NUM_FU), .CDB_W(CDB_W), .BUF_DEPTH(BUF_DEPTH),
                    .ROB_W(ROB_W), .PR_W(PR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .en(en), .rollback_en(rollback_en),
    .rollback_rob_idx(rollback_rob_idx), .diff_rob(diff_rob),
    .fu_done(fu_done), .fu_t_idx(fu_t_idx), .fu_rob_idx(fu_rob_idx),
    .fu_dest_idx(fu_dest_idx), .fu_result(fu_result), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_t_idx(cdb_t_idx), .cdb_rob_idx(cdb_rob_idx),
    .cdb_dest_idx(cdb_dest_idx), .cdb_value(cdb_value)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0]       port;
    logic [PR_W-1:0]   t;
    logic [ROB_W-1:0]  rob;
    logic [4:0]        dest;
    logic [DATA_W-1:0] val;
  } rec_t;

  rec_t sb[$];
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int fu, input logic [PR_W-1:0] t, input logic [ROB_W-1:0] rob,
                       input logic [DATA_W-1:0] val);
    fu_done[fu]                       = 1'b1;
    fu_t_idx[fu*PR_W +: PR_W]         = t;
    fu_rob_idx[fu*ROB_W +: ROB_W]     = rob;
    fu_dest_idx[fu*5 +: 5]            = 5'(fu + 1);
    fu_result[fu*DATA_W +: DATA_W]    = val;
  endtask

  task automatic exp_b(input int port, input int fu, input logic [PR_W-1:0] t,
                       input logic [ROB_W-1:0] rob, input logic [DATA_W-1:0] val);
    rec_t r;
    r.port = 32'(port);
    r.t    = t;
    r.rob  = rob;
    r.dest = 5'(fu + 1);
    r.val  = val;
    sb.push_back(r);
  endtask

  // Monitor: every valid port is matched against the oldest expected broadcast.
  always @(negedge clock) begin
    rec_t e;
    for (int p = 0; p < CDB_W; p++) begin
      if (cdb_valid[p]) begin
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_bcast: port %0d rob %0d tag %0d, nothing expected",
                   p, cdb_rob_idx[p*ROB_W +: ROB_W], cdb_t_idx[p*PR_W +: PR_W]);
        end else begin
          e = sb.pop_front();
          if (e.port != 32'(p) || e.t !== cdb_t_idx[p*PR_W +: PR_W] ||
              e.rob !== cdb_rob_idx[p*ROB_W +: ROB_W] || e.dest !== cdb_dest_idx[p*5 +: 5] ||
              e.val !== cdb_value[p*DATA_W +: DATA_W]) begin
            n_fail++;
            $display("FAIL bcast_data: got port %0d tag %0d rob %0d dest %0d val 0x%0h, required port %0d tag %0d rob %0d dest %0d val 0x%0h",
                     p, cdb_t_idx[p*PR_W +: PR_W], cdb_rob_idx[p*ROB_W +: ROB_W],
                     cdb_dest_idx[p*5 +: 5], cdb_value[p*DATA_W +: DATA_W],
                     e.port, e.t, e.rob, e.dest, e.val);
          end
        end
      end
    end
  end

  initial begin
    // Reset held two cycles while every FU asserts done.
    reset = 1'b0;
    en    = 1'b1;
    for (int f = 0; f < NUM_FU; f++) drive(f, 6'(f + 1), 5'(f), 64'(f + 100));
    step();
    #2 chk("reset_valid_c1", 64'(cdb_valid), 64'h0);
    step();
    #2 chk("reset_valid_c2", 64'(cdb_valid), 64'h0);
    step();
    reset   = 1'b1;
    fu_done = '0;
    #1 chk("post_reset_ready", 64'(fu_ready), 64'h3f);
    chk("post_reset_empty", 64'(cdb_valid), 64'h0);

    // Single result from FU2: broadcast the next cycle only.
    drive(2, 6'd9, 5'd2, 64'hDEAD);
    step();
    fu_done = '0;
    exp_b(0, 2, 6'd9, 5'd2, 64'hDEAD);
    #2 chk("t2_port1_idle", 64'(cdb_valid[1]), 64'h0);
    step();
    #2 chk("t2_after_idle", 64'(cdb_valid), 64'h0);

    // FU5 broadcast wraps rr_ptr back to 0.
    drive(5, 6'd7, 5'd4, 64'h55);
    step();
    fu_done = '0;
    exp_b(0, 5, 6'd7, 5'd4, 64'h55);
    step();

    // FU0, FU1, FU4 together from rr_ptr=0.
    drive(0, 6'd10, 5'd5, 64'hA0);
    drive(1, 6'd11, 5'd6, 64'hA1);
    drive(4, 6'd12, 5'd7, 64'hA4);
    step();
    fu_done = '0;
    exp_b(0, 0, 6'd10, 5'd5, 64'hA0);
    exp_b(1, 1, 6'd11, 5'd6, 64'hA1);
    #2 chk("t3_c1_valid", 64'(cdb_valid), 64'h3);
    step();
    exp_b(0, 4, 6'd12, 5'd7, 64'hA4);
    step();
    chk("t3_drained", 64'(sb.size()), 64'h0);

    // FU3 backpressure with rr_ptr=5 and ports kept busy by FU5/FU0 then FU1/FU2.
    drive(3, 6'd20, 5'd8, 64'hB30);
    drive(5, 6'd21, 5'd9, 64'hB5);
    drive(0, 6'd22, 5'd10, 64'hB0);
    drive(1, 6'd23, 5'd11, 64'hB1);
    drive(2, 6'd24, 5'd12, 64'hB2);
    step();
    fu_done = '0;
    drive(3, 6'd25, 5'd13, 64'hB31);
    exp_b(0, 5, 6'd21, 5'd9, 64'hB5);
    exp_b(1, 0, 6'd22, 5'd10, 64'hB0);
    #2 chk("t4_ready_c1", 64'(fu_ready[3]), 64'h1);
    step();
    drive(3, 6'd26, 5'd14, 64'hB32);
    exp_b(0, 1, 6'd23, 5'd11, 64'hB1);
    exp_b(1, 2, 6'd24, 5'd12, 64'hB2);
    #2 chk("t4_full_c2", 64'(fu_ready[3]), 64'h0);
    step();
    exp_b(0, 3, 6'd20, 5'd8, 64'hB30);
    #2 chk("t4_full_c3_pop_no_free", 64'(fu_ready[3]), 64'h0);
    step();
    exp_b(0, 3, 6'd25, 5'd13, 64'hB31);
    #2 chk("t4_ready_c4", 64'(fu_ready[3]), 64'h1);
    step();
    fu_done = '0;
    exp_b(0, 3, 6'd26, 5'd14, 64'hB32);
    #2 chk("t4_ready_c5", 64'(fu_ready[3]), 64'h1);
    step();
    chk("t4_drained", 64'(sb.size()), 64'h0);

    // Rollback with ROB wrap: 31 and 1 squashed, 3 survives; push of 2 dropped, push of 30 kept.
    drive(0, 6'd30, 5'd31, 64'hC0);
    drive(1, 6'd31, 5'd1, 64'hC1);
    drive(2, 6'd32, 5'd3, 64'hC2);
    step();
    fu_done          = '0;
    rollback_en      = 1'b1;
    rollback_rob_idx = 5'd30;
    diff_rob         = 5'd4;
    drive(5, 6'd33, 5'd2, 64'hC5);
    drive(3, 6'd34, 5'd30, 64'hC3);
    exp_b(0, 2, 6'd32, 5'd3, 64'hC2);
    #2 chk("t5_valid_mask", 64'(cdb_valid), 64'h1);
    step();
    rollback_en = 1'b0;
    fu_done     = '0;
    exp_b(0, 3, 6'd34, 5'd30, 64'hC3);
    step();
    chk("t5_drained", 64'(sb.size()), 64'h0);

    // Fill buffers, freeze with en=0, roll back 11..15 mid-freeze, then resume.
    drive(0, 6'd40, 5'd8, 64'hD0);
    drive(1, 6'd41, 5'd9, 64'hD1);
    drive(2, 6'd42, 5'd12, 64'hD2);
    drive(3, 6'd43, 5'd10, 64'hD3);
    drive(4, 6'd44, 5'd16, 64'hD4);
    drive(5, 6'd45, 5'd17, 64'hD5);
    step();
    drive(0, 6'd46, 5'd11, 64'hE0);
    drive(1, 6'd47, 5'd13, 64'hE1);
    drive(2, 6'd48, 5'd14, 64'hE2);
    drive(3, 6'd49, 5'd15, 64'hE3);
    drive(4, 6'd50, 5'd18, 64'hE4);
    drive(5, 6'd51, 5'd20, 64'hE5);
    exp_b(0, 4, 6'd44, 5'd16, 64'hD4);
    exp_b(1, 5, 6'd45, 5'd17, 64'hD5);
    step();
    fu_done = '0;
    en      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        rollback_en      = 1'b1;
        rollback_rob_idx = 5'd10;
        diff_rob         = 5'd5;
      end else begin
        rollback_en = 1'b0;
      end
      #2 chk("t6_frozen_valid", 64'(cdb_valid), 64'h0);
      chk("t6_frozen_ready", 64'(fu_ready), 64'h0);
      step();
    end
    rollback_en = 1'b0;
    en          = 1'b1;
    exp_b(0, 0, 6'd40, 5'd8, 64'hD0);
    exp_b(1, 1, 6'd41, 5'd9, 64'hD1);
    step();
    exp_b(0, 3, 6'd43, 5'd10, 64'hD3);
    exp_b(1, 4, 6'd50, 5'd18, 64'hE4);
    step();
    exp_b(0, 5, 6'd51, 5'd20, 64'hE5);
    step();
    chk("t6_drained", 64'(sb.size()), 64'h0);

    // Reset mid-operation: buffered result is dropped and nothing is broadcast.
    drive(0, 6'd60, 5'd21, 64'hF0);
    step();
    fu_done = '0;
    reset   = 1'b0;
    #2 chk("t7_reset_cycle_valid", 64'(cdb_valid), 64'h0);
    step();
    reset = 1'b1;
    #1 chk("t7_ready_after_reset", 64'(fu_ready), 64'h3f);
    step();
    #2 chk("t7_no_bcast", 64'(cdb_valid), 64'h0);
    step();
    chk("final_drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
